pipelined_cla_adder: RTL and testbench
======================================

PIPELINED_CLA_ADDER -- requirements
Module: pipelined_cla_adder

Interface
REQ-001 Parameter: WIDTH, 16, operand/sum width in bits; WIDTH SHALL be a multiple of BLOCK*STAGES.
REQ-002 Parameter: BLOCK, 4, carry-lookahead group width in bits.
REQ-003 Parameter: STAGES, 2, number of pipeline stages, range 1..WIDTH/BLOCK.
REQ-004 Clocking: one clock; reset is asynchronous and active-low.
REQ-005 clk  input  1  clock; all state updates on its rising edge.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 in_valid  input  1  operand set on a, b, carry_in, sub is valid.
REQ-008 in_ready  output  1  block accepts an operand set this cycle.
REQ-009 a  input  WIDTH  operand A.
REQ-010 b  input  WIDTH  operand B.
REQ-011 carry_in  input  1  carry into bit 0; ignored when sub=1.
REQ-012 sub  input  1  0 = A+B+carry_in; 1 = A-B, computed as A+~B+1.
REQ-013 out_valid  output  1  sum, carry_out and overflow hold a valid result.
REQ-014 out_ready  input  1  downstream accepts the result this cycle.
REQ-015 sum  output  WIDTH  result modulo 2^WIDTH.
REQ-016 carry_out  output  1  carry out of bit WIDTH-1; for sub, 1 means no borrow.
REQ-017 overflow  output  1  two's-complement signed overflow: carry into MSB XOR carry out of MSB.

Function
REQ-018 Datapath split: WIDTH into STAGES equal slices, slice k = bits [(k+1)*WIDTH/STAGES-1 : k*WIDTH/STAGES], LSB slice first.
REQ-019 Slice logic: stage k computes slice k with BLOCK-bit lookahead groups; generate/propagate per group; group carries via lookahead, not ripple, inside a slice.
REQ-020 Inter-stage carry: registered carry of slice k feeds slice k+1 in the next stage.
REQ-021 Skew: stage k registers the unprocessed upper operand bits, the completed lower sum bits, and the sub flag, so every result leaves fully aligned.
REQ-022 Latency: with out_ready held 1, result of a transfer accepted at edge n appears with out_valid=1 after edge n+STAGES-1, i.e. STAGES register stages, throughput one result per cycle.
REQ-023 Transfer: input transfer occurs on a rising edge with in_valid=1 and in_ready=1; output transfer on a rising edge with out_valid=1 and out_ready=1.
REQ-024 Per-stage valid bit; stage k loads when empty or when stage k+1 (or the output, for the last stage) transfers in the same cycle.
REQ-025 Bubble collapse: empty stages SHALL be filled while later stages stall.
REQ-026 in_ready = stage 0 empty OR stage 0 advancing this cycle; combinational path from out_ready to in_ready permitted.
REQ-027 Backpressure: while out_valid=1 and out_ready=0, sum, carry_out and overflow SHALL hold stable and no data is lost or duplicated.
REQ-028 Full pipeline with out_ready=0: in_ready=0; input ignored.
REQ-029 Simultaneous accept on input and output in a full pipeline: both transfers occur, occupancy unchanged.
REQ-030 Order: results leave in acceptance order.
REQ-031 STAGES=1: single output register, latency 1 cycle, same handshake rules.
REQ-032 Wrap-around: sum wraps modulo 2^WIDTH; carry_out carries the lost bit.
REQ-033 in_valid=0 or data changes while in_ready=0 SHALL not affect pipeline contents.

Reset
REQ-034 rst_n=0: all stage valid bits cleared immediately (asynchronous); out_valid=0, sum=0, carry_out=0, overflow=0.
REQ-035 in_ready SHALL read 0 while rst_n=0 and 1 on the first cycle after rst_n deasserts.
REQ-036 Reset mid-operation: all in-flight results discarded, none emitted after release.

Verification (WIDTH=16, STAGES=2 unless stated)
REQ-037 a=10, b=22, carry_in=0, then carry_in=1, out_ready=1 -> sum=32 then 33, carry_out=0, overflow=0, consecutive cycles, latency 2.
REQ-038 a=32768, b=65535, ci=0 -> sum=32767, carry_out=1, overflow=1; a=32767, b=32767, ci=1 -> sum=65535, carry_out=0, overflow=1.
REQ-039 a=65535, b=65535, ci=0 -> sum=65534, carry_out=1, overflow=0; a=32768, b=32768 -> sum=0, carry_out=1, overflow=1.
REQ-040 sub=1, a=5, b=7 -> sum=65534, carry_out=0, overflow=0; sub=1, a=7, b=5, carry_in=1 -> sum=2, carry_out=1.
REQ-041 Backpressure: stream 4 sets, out_ready=0 for 5 cycles -> in_ready=0 after 2 accepted, output held; then release -> all 4 results in order, none lost.
REQ-042 Reset: assert rst_n=0 with 2 results in flight -> out_valid=0 at once; after release no stale result; repeat REQ-037 with STAGES=1 and STAGES=4 -> identical values, latency 1 and 4.

Source files
------------

// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-lookahead adder/subtractor: WIDTH bits split into STAGES slices,
// one slice per register stage, with a valid/ready handshake and bubble collapse.
module pipelined_cla_adder #(
  parameter int WIDTH  = 16,
  parameter int BLOCK  = 4,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow
);

  localparam int SW = WIDTH / STAGES;
  localparam int NG = SW / BLOCK;

  // Returns carries c[0..SW] of one slice; group and bit carries are flattened
  // sum-of-products terms so no carry ripples through a chain of groups.
  function automatic logic [SW:0] cla_carries(input logic [SW-1:0] x,
                                              input logic [SW-1:0] y,
                                              input logic          cin);
    logic [SW-1:0] g;
    logic [SW-1:0] p;
    logic [NG-1:0] gg;
    logic [NG-1:0] gp;
    logic [NG:0]   gc;
    logic [SW:0]   c;
    logic          term;
    g  = x & y;
    p  = x ^ y;
    gg = '0;
    gp = '0;
    gc = '0;
    c  = '0;
    for (int i = 0; i < NG; i++) begin
      gp[i] = &p[i*BLOCK +: BLOCK];
      for (int s = 0; s < BLOCK; s++) begin
        term = g[i*BLOCK+s];
        for (int u = s + 1; u < BLOCK; u++) term = term & p[i*BLOCK+u];
        gg[i] = gg[i] | term;
      end
    end
    gc[0] = cin;
    for (int j = 0; j < NG; j++) begin
      term = cin;
      for (int m = 0; m <= j; m++) term = term & gp[m];
      gc[j+1] = term;
      for (int i = 0; i <= j; i++) begin
        term = gg[i];
        for (int m = i + 1; m <= j; m++) term = term & gp[m];
        gc[j+1] = gc[j+1] | term;
      end
    end
    for (int i = 0; i < NG; i++) begin
      c[i*BLOCK] = gc[i];
      for (int t = 0; t < BLOCK - 1; t++) begin
        term = gc[i];
        for (int u = 0; u <= t; u++) term = term & p[i*BLOCK+u];
        c[i*BLOCK+t+1] = term;
        for (int s = 0; s <= t; s++) begin
          term = g[i*BLOCK+s];
          for (int u = s + 1; u <= t; u++) term = term & p[i*BLOCK+u];
          c[i*BLOCK+t+1] = c[i*BLOCK+t+1] | term;
        end
      end
    end
    c[SW] = gc[NG];
    return c;
  endfunction

  logic [STAGES-1:0][WIDTH-1:0] w_a_q;
  logic [STAGES-1:0][WIDTH-1:0] w_b_q;
  logic [STAGES-1:0][WIDTH-1:0] w_sum_q;
  logic [STAGES-1:0]            w_sub_q;
  logic [STAGES-1:0]            w_c_q;
  logic [STAGES-1:0]            w_v_q;
  logic [STAGES-1:0]            w_ovf_q;
  logic [STAGES:0]              w_room;
  logic                         w_unused;

  // A stage can load when it is empty or its content moves on this cycle.
  always_comb begin
    w_room         = '0;
    w_room[STAGES] = out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      w_room[k] = ~w_v_q[k] | w_room[k+1];
    end
  end

  assign in_ready  = rst_n & w_room[0];
  assign out_valid = w_v_q[STAGES-1];
  assign sum       = w_sum_q[STAGES-1];
  assign carry_out = w_c_q[STAGES-1];
  assign overflow  = w_ovf_q[STAGES-1];

  // Operands and partial overflow of the final stage are never consumed.
  assign w_unused = &{1'b0, w_a_q[STAGES-1], w_b_q[STAGES-1], w_sub_q[STAGES-1], w_ovf_q};

  genvar gi;
  for (gi = 0; gi < STAGES; gi++) begin : g_stage
    localparam int LO = gi * SW;

    logic [WIDTH-1:0] w_src_a;
    logic [WIDTH-1:0] w_src_b;
    logic [WIDTH-1:0] w_src_sum;
    logic [WIDTH-1:0] w_sum_nxt;
    logic             w_src_sub;
    logic             w_src_c;
    logic             w_src_v;
    logic [SW-1:0]    w_x;
    logic [SW-1:0]    w_y;
    logic [SW-1:0]    w_s;
    logic [SW:0]      w_c;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sum;
    logic             r_sub;
    logic             r_c;
    logic             r_v;
    logic             r_ovf;

    if (gi == 0) begin : g_head
      assign w_src_a   = a;
      assign w_src_b   = b;
      assign w_src_sub = sub;
      assign w_src_c   = sub | carry_in;
      assign w_src_v   = in_valid;
      assign w_src_sum = '0;
    end else begin : g_link
      assign w_src_a   = w_a_q[gi-1];
      assign w_src_b   = w_b_q[gi-1];
      assign w_src_sub = w_sub_q[gi-1];
      assign w_src_c   = w_c_q[gi-1];
      assign w_src_v   = w_v_q[gi-1];
      assign w_src_sum = w_sum_q[gi-1];
    end

    // Subtraction inverts B slice by slice; the +1 enters as stage-0 carry.
    assign w_x = w_src_a[LO +: SW];
    assign w_y = w_src_b[LO +: SW] ^ {SW{w_src_sub}};
    assign w_c = cla_carries(w_x, w_y, w_src_c);
    assign w_s = w_x ^ w_y ^ w_c[SW-1:0];

    // Sum bits at and above this slice are still zero in the incoming word.
    assign w_sum_nxt = w_src_sum | (WIDTH'(w_s) << LO);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_v   <= 1'b0;
        r_a   <= '0;
        r_b   <= '0;
        r_sum <= '0;
        r_sub <= 1'b0;
        r_c   <= 1'b0;
        r_ovf <= 1'b0;
      end else if (w_room[gi]) begin
        r_v <= w_src_v;
        if (w_src_v) begin
          r_a   <= w_src_a;
          r_b   <= w_src_b;
          r_sum <= w_sum_nxt;
          r_sub <= w_src_sub;
          r_c   <= w_c[SW];
          r_ovf <= w_c[SW] ^ w_c[SW-1];
        end
      end
    end

    assign w_a_q[gi]   = r_a;
    assign w_b_q[gi]   = r_b;
    assign w_sum_q[gi] = r_sum;
    assign w_sub_q[gi] = r_sub;
    assign w_c_q[gi]   = r_c;
    assign w_v_q[gi]   = r_v;
    assign w_ovf_q[gi] = r_ovf;
  end

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Bench for pipelined_cla_adder: scoreboard on the STAGES=2 instance plus
// latency checks on STAGES=1 and STAGES=4 instances.
module tb_pipelined_cla_adder;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         alt_valid = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         carry_in = 1'b0;
  logic         sub = 1'b0;
  logic         out_ready = 1'b0;

  logic         in_ready, out_valid, carry_out, overflow;
  logic [W-1:0] sum;
  logic         s1_in_ready, s1_out_valid, s1_co, s1_ov;
  logic [W-1:0] s1_sum;
  logic         s4_in_ready, s4_out_valid, s4_co, s4_ov;
  logic [W-1:0] s4_sum;

  int n_tests = 0;
  int n_fail  = 0;

  logic [W+1:0] sb_q[$];
  logic [W+1:0] mon_exp;

  logic [W-1:0] cv_a   [6] = '{16'd32768, 16'd32767, 16'd65535, 16'd32768, 16'd5, 16'd7};
  logic [W-1:0] cv_b   [6] = '{16'd65535, 16'd32767, 16'd65535, 16'd32768, 16'd7, 16'd5};
  logic         cv_ci  [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
  logic         cv_sub [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
  logic [W+1:0] cv_exp [6] = '{{1'b1, 1'b1, 16'd32767}, {1'b1, 1'b0, 16'd65535},
                               {1'b0, 1'b1, 16'd65534}, {1'b1, 1'b1, 16'd0},
                               {1'b0, 1'b0, 16'd65534}, {1'b0, 1'b1, 16'd2}};

  pipelined_cla_adder #(.WIDTH(W), .BLOCK(4), .STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .carry_in(carry_in), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .carry_out(carry_out), .overflow(overflow)
  );

  pipelined_cla_adder #(.WIDTH(W), .BLOCK(4), .STAGES(1)) dut_s1 (
    .clk(clk), .rst_n(rst_n), .in_valid(alt_valid), .in_ready(s1_in_ready),
    .a(a), .b(b), .carry_in(carry_in), .sub(sub),
    .out_valid(s1_out_valid), .out_ready(out_ready),
    .sum(s1_sum), .carry_out(s1_co), .overflow(s1_ov)
  );

  pipelined_cla_adder #(.WIDTH(W), .BLOCK(4), .STAGES(4)) dut_s4 (
    .clk(clk), .rst_n(rst_n), .in_valid(alt_valid), .in_ready(s4_in_ready),
    .a(a), .b(b), .carry_in(carry_in), .sub(sub),
    .out_valid(s4_out_valid), .out_ready(out_ready),
    .sum(s4_sum), .carry_out(s4_co), .overflow(s4_ov)
  );

  always #5 clk = ~clk;

  // Reference: {overflow, carry_out, sum}; overflow from operand/result signs.
  function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic ci, input logic s);
    logic [W-1:0] yy;
    logic [W:0]   t;
    logic         ov;
    yy = s ? ~y : y;
    t  = {1'b0, x} + {1'b0, yy} + {{W{1'b0}}, (s ? 1'b1 : ci)};
    ov = (x[W-1] == yy[W-1]) && (t[W-1] != x[W-1]);
    return {ov, t};
  endfunction

  // Scoreboard for the STAGES=2 instance, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb_q.delete();
    end else begin
      if (in_valid && in_ready) sb_q.push_back(model(a, b, carry_in, sub));
      if (out_valid && out_ready) begin
        n_tests++;
        if (sb_q.size() == 0) begin
          n_fail++;
          $display("FAIL scoreboard_stale: got sum=%0d co=%0d ov=%0d, required no output", sum, carry_out, overflow);
        end else begin
          mon_exp = sb_q.pop_front();
          if ({overflow, carry_out, sum} !== mon_exp) begin
            n_fail++;
            $display("FAIL scoreboard: got ov=%0d co=%0d sum=%0d, required ov=%0d co=%0d sum=%0d",
                     overflow, carry_out, sum, mon_exp[W+1], mon_exp[W], mon_exp[W-1:0]);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    n_tests++;
    if ({out_valid, carry_out, overflow, sum} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got v=%0d co=%0d ov=%0d sum=%0d, required all 0", out_valid, carry_out, overflow, sum);
    end
    n_tests++;
    if ({in_ready, s1_in_ready, s4_in_ready} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_in_ready: got %b, required 000", {in_ready, s1_in_ready, s4_in_ready});
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    n_tests++;
    if ({in_ready, s1_in_ready, s4_in_ready} !== 3'b111) begin
      n_fail++;
      $display("FAIL release_in_ready: got %b, required 111", {in_ready, s1_in_ready, s4_in_ready});
    end
  endtask

  task automatic test_basic();
    out_ready = 1'b1;
    sub = 1'b0;
    a = 16'd10;
    b = 16'd22;
    carry_in = 1'b0;
    in_valid = 1'b1;
    tick();
    n_tests++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_latency_early: got out_valid=%0d, required 0", out_valid);
    end
    carry_in = 1'b1;
    tick();
    in_valid = 1'b0;
    n_tests++;
    if ({out_valid, carry_out, overflow, sum} !== {3'b100, 16'd32}) begin
      n_fail++;
      $display("FAIL basic_first: got v=%0d co=%0d ov=%0d sum=%0d, required v=1 co=0 ov=0 sum=32", out_valid, carry_out, overflow, sum);
    end
    tick();
    n_tests++;
    if ({out_valid, carry_out, overflow, sum} !== {3'b100, 16'd33}) begin
      n_fail++;
      $display("FAIL basic_second: got v=%0d co=%0d ov=%0d sum=%0d, required v=1 co=0 ov=0 sum=33", out_valid, carry_out, overflow, sum);
    end
    tick();
    n_tests++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_drain: got out_valid=%0d, required 0", out_valid);
    end
  endtask

  task automatic test_corners();
    int  issued;
    int  got;
    logic took;
    issued = 0;
    got = 0;
    out_ready = 1'b1;
    a = cv_a[0]; b = cv_b[0]; carry_in = cv_ci[0]; sub = cv_sub[0];
    in_valid = 1'b1;
    for (int cyc = 0; cyc < 40 && got < 6; cyc++) begin
      @(negedge clk);
      took = in_valid && in_ready;
      if (out_valid && out_ready) begin
        n_tests++;
        if ({overflow, carry_out, sum} !== cv_exp[got]) begin
          n_fail++;
          $display("FAIL corner_%0d: got ov=%0d co=%0d sum=%0d, required ov=%0d co=%0d sum=%0d", got,
                   overflow, carry_out, sum, cv_exp[got][W+1], cv_exp[got][W], cv_exp[got][W-1:0]);
        end
        got++;
      end
      @(posedge clk);
      #1;
      if (took) issued++;
      if (issued < 6) begin
        a = cv_a[issued]; b = cv_b[issued]; carry_in = cv_ci[issued]; sub = cv_sub[issued];
      end else begin
        in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    n_tests++;
    if (got != 6) begin
      n_fail++;
      $display("FAIL corner_count: got %0d results, required 6", got);
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] va [4];
    logic [W-1:0] vb [4];
    logic         vc [4];
    logic         vs [4];
    logic [W+1:0] ve [4];
    int   issued;
    int   got;
    logic took;
    for (int i = 0; i < 4; i++) begin
      va[i] = W'($urandom); vb[i] = W'($urandom);
      vc[i] = 1'($urandom_range(0, 1)); vs[i] = 1'($urandom_range(0, 1));
      ve[i] = model(va[i], vb[i], vc[i], vs[i]);
    end
    issued = 0;
    got = 0;
    out_ready = 1'b0;
    a = va[0]; b = vb[0]; carry_in = vc[0]; sub = vs[0];
    in_valid = 1'b1;
    for (int c = 0; c < 40 && got < 4; c++) begin
      @(negedge clk);
      took = in_valid && in_ready;
      if (c >= 2 && c <= 6) begin
        n_tests++;
        if (in_ready !== 1'b0) begin
          n_fail++;
          $display("FAIL bp_in_ready_c%0d: got %0d, required 0", c, in_ready);
        end
        n_tests++;
        if ({out_valid, overflow, carry_out, sum} !== {1'b1, ve[0]}) begin
          n_fail++;
          $display("FAIL bp_hold_c%0d: got v=%0d ov=%0d co=%0d sum=%0d, required v=1 ov=%0d co=%0d sum=%0d", c,
                   out_valid, overflow, carry_out, sum, ve[0][W+1], ve[0][W], ve[0][W-1:0]);
        end
      end
      if (out_valid && out_ready) begin
        n_tests++;
        if ({overflow, carry_out, sum} !== ve[got]) begin
          n_fail++;
          $display("FAIL bp_order_%0d: got ov=%0d co=%0d sum=%0d, required ov=%0d co=%0d sum=%0d", got,
                   overflow, carry_out, sum, ve[got][W+1], ve[got][W], ve[got][W-1:0]);
        end
        got++;
      end
      @(posedge clk);
      #1;
      if (took) issued++;
      out_ready = (c + 1 >= 7);
      if (issued < 4) begin
        a = va[issued]; b = vb[issued]; carry_in = vc[issued]; sub = vs[issued];
      end else begin
        in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    n_tests++;
    if (got != 4) begin
      n_fail++;
      $display("FAIL bp_count: got %0d results, required 4", got);
    end
  endtask

  task automatic test_back_to_back();
    logic [W+1:0] ve [10];
    logic [W-1:0] va [10];
    logic [W-1:0] vb [10];
    logic         vc [10];
    logic         vs [10];
    int   issued;
    int   got;
    int   first_c;
    int   last_c;
    logic took;
    for (int i = 0; i < 10; i++) begin
      va[i] = W'($urandom); vb[i] = W'($urandom);
      vc[i] = 1'($urandom_range(0, 1)); vs[i] = 1'($urandom_range(0, 1));
      ve[i] = model(va[i], vb[i], vc[i], vs[i]);
    end
    issued = 0; got = 0; first_c = -1; last_c = -1;
    out_ready = 1'b1;
    a = va[0]; b = vb[0]; carry_in = vc[0]; sub = vs[0];
    in_valid = 1'b1;
    for (int c = 0; c < 40 && got < 10; c++) begin
      @(negedge clk);
      took = in_valid && in_ready;
      if (issued < 10) begin
        n_tests++;
        if (in_ready !== 1'b1) begin
          n_fail++;
          $display("FAIL b2b_in_ready_c%0d: got %0d, required 1", c, in_ready);
        end
      end
      if (out_valid && out_ready) begin
        if (first_c < 0) first_c = c;
        last_c = c;
        n_tests++;
        if ({overflow, carry_out, sum} !== ve[got]) begin
          n_fail++;
          $display("FAIL b2b_%0d: got ov=%0d co=%0d sum=%0d, required ov=%0d co=%0d sum=%0d", got,
                   overflow, carry_out, sum, ve[got][W+1], ve[got][W], ve[got][W-1:0]);
        end
        got++;
      end
      @(posedge clk);
      #1;
      if (took) issued++;
      if (issued < 10) begin
        a = va[issued]; b = vb[issued]; carry_in = vc[issued]; sub = vs[issued];
      end else begin
        in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    n_tests++;
    if (got != 10 || last_c - first_c != 9) begin
      n_fail++;
      $display("FAIL b2b_throughput: got %0d results over %0d cycles, required 10 over 10", got, last_c - first_c + 1);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 80; c++) begin
      tick();
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      a = W'($urandom); b = W'($urandom);
      carry_in = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
    end
    tick();
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 20 && (out_valid || sb_q.size() != 0); c++) tick();
    n_tests++;
    if (sb_q.size() != 0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL random_drain: got %0d pending, out_valid=%0d, required 0 pending, 0", sb_q.size(), out_valid);
    end
  endtask

  task automatic test_reset_midflight();
    out_ready = 1'b0;
    a = 16'd100; b = 16'd200; carry_in = 1'b0; sub = 1'b0;
    in_valid = 1'b1;
    tick();
    a = 16'd300;
    tick();
    in_valid = 1'b0;
    tick();
    n_tests++;
    if (out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL midreset_setup: got out_valid=%0d, required 1", out_valid);
    end
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({out_valid, in_ready, sum} !== '0) begin
      n_fail++;
      $display("FAIL midreset_async: got v=%0d rdy=%0d sum=%0d, required 0 0 0", out_valid, in_ready, sum);
    end
    tick();
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      n_tests++;
      if (out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL midreset_stale_c%0d: got out_valid=%0d sum=%0d, required out_valid=0", c, out_valid, sum);
      end
    end
  endtask

  task automatic test_stages();
    out_ready = 1'b1;
    in_valid = 1'b0;
    sub = 1'b0;
    a = 16'd10; b = 16'd22; carry_in = 1'b0;
    alt_valid = 1'b1;
    #1;
    n_tests++;
    if ({s1_in_ready, s4_in_ready} !== 2'b11) begin
      n_fail++;
      $display("FAIL stages_ready: got %b, required 11", {s1_in_ready, s4_in_ready});
    end
    tick();
    n_tests++;
    if ({s1_out_valid, s1_co, s1_ov, s1_sum, s4_out_valid} !== {3'b100, 16'd32, 1'b0}) begin
      n_fail++;
      $display("FAIL s1_first: got v=%0d co=%0d ov=%0d sum=%0d s4v=%0d, required v=1 co=0 ov=0 sum=32 s4v=0",
               s1_out_valid, s1_co, s1_ov, s1_sum, s4_out_valid);
    end
    carry_in = 1'b1;
    tick();
    alt_valid = 1'b0;
    n_tests++;
    if ({s1_out_valid, s1_co, s1_ov, s1_sum} !== {3'b100, 16'd33}) begin
      n_fail++;
      $display("FAIL s1_second: got v=%0d co=%0d ov=%0d sum=%0d, required v=1 co=0 ov=0 sum=33", s1_out_valid, s1_co, s1_ov, s1_sum);
    end
    tick();
    n_tests++;
    if ({s1_out_valid, s4_out_valid} !== 2'b00) begin
      n_fail++;
      $display("FAIL stages_gap: got s1v=%0d s4v=%0d, required 0 0", s1_out_valid, s4_out_valid);
    end
    tick();
    n_tests++;
    if ({s4_out_valid, s4_co, s4_ov, s4_sum} !== {3'b100, 16'd32}) begin
      n_fail++;
      $display("FAIL s4_first: got v=%0d co=%0d ov=%0d sum=%0d, required v=1 co=0 ov=0 sum=32", s4_out_valid, s4_co, s4_ov, s4_sum);
    end
    tick();
    n_tests++;
    if ({s4_out_valid, s4_co, s4_ov, s4_sum} !== {3'b100, 16'd33}) begin
      n_fail++;
      $display("FAIL s4_second: got v=%0d co=%0d ov=%0d sum=%0d, required v=1 co=0 ov=0 sum=33", s4_out_valid, s4_co, s4_ov, s4_sum);
    end
    tick();
    n_tests++;
    if (s4_out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL s4_drain: got out_valid=%0d, required 0", s4_out_valid);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_corners();
    test_backpressure();
    test_back_to_back();
    test_random();
    test_reset_midflight();
    test_stages();
    tick();
    n_tests++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL final_scoreboard: got %0d pending, required 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
